// File: rtl/umi_stream_arbiter_if.sv
// Purpose: bundles the N UMI request streams, the merged UMI output and the arbiter status.
// Latency: wiring only, no state.
// Backpressure: per-port ready towards the sources, single ready from the downstream consumer.
interface umi_stream_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*CW-1:0] in_cmd;
    logic [N*AW-1:0] in_dstaddr;
    logic [N*AW-1:0] in_srcaddr;
    logic [N*DW-1:0] in_data;

    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_cmd;
    logic [AW-1:0]   out_dstaddr;
    logic [AW-1:0]   out_srcaddr;
    logic [DW-1:0]   out_data;

    logic            locked;
    logic [GW-1:0]   grant_id;

    // Environment side: sources drive the inputs, the consumer drives out_ready.
    modport master (
        output in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
        input  in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
        input  locked, grant_id
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
        output in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
        output locked, grant_id
    );
endinterface

// File: rtl/umi_stream_arbiter.sv
// Purpose: round-robin merge of N UMI request streams, grant held until end-of-message.
// Latency: one cycle from beat accept to out_valid (single registered output stage).
// Backpressure: out_valid && !out_ready holds the output and drops every in_ready.
module umi_stream_arbiter #(
    parameter int N       = 2,
    parameter int DW      = 256,
    parameter int AW      = 64,
    parameter int CW      = 32,
    parameter int EOM_BIT = 22
) (
    input logic                 clk,
    input logic                 nreset,
    umi_stream_arbiter_if.slave bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    // Arbitration state
    logic [GW-1:0] ptr;        // last port that completed a packet
    logic [GW-1:0] lock_idx;   // port owning the packet in progress
    logic          locked_q;
    logic [GW-1:0] grant_q;

    // Output stage
    logic          out_valid_q;
    logic [CW-1:0] out_cmd_q;
    logic [AW-1:0] out_dstaddr_q;
    logic [AW-1:0] out_srcaddr_q;
    logic [DW-1:0] out_data_q;

    // Combinational selection
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    logic          sel_valid;
    logic [CW-1:0] sel_cmd;
    logic [AW-1:0] sel_dstaddr;
    logic [AW-1:0] sel_srcaddr;
    logic [DW-1:0] sel_data;
    logic          load;
    logic          accept;
    logic [N-1:0]  ready_c;

    // The output slot can take a new beat when empty or draining this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Pick the port to serve: the locked owner, else first valid port after ptr.
    always_comb begin
        sel   = lock_idx;
        found = 1'b0;
        idx   = 0;
        if (!locked_q) begin
            sel = ptr;
            for (int k = 1; k <= N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                for (int i = 0; i < N; i++) begin
                    if (!found && (i == idx) && bus.in_valid[i]) begin
                        sel   = GW'(i);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    // Mux the selected port's valid and payload using constant slices only.
    always_comb begin
        sel_valid   = 1'b0;
        sel_cmd     = '0;
        sel_dstaddr = '0;
        sel_srcaddr = '0;
        sel_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == GW'(i)) begin
                sel_valid   = bus.in_valid[i];
                sel_cmd     = bus.in_cmd[i*CW +: CW];
                sel_dstaddr = bus.in_dstaddr[i*AW +: AW];
                sel_srcaddr = bus.in_srcaddr[i*AW +: AW];
                sel_data    = bus.in_data[i*DW +: DW];
            end
        end
    end

    // Nothing is accepted while reset is asserted, so ready stays low then too.
    assign accept = nreset && load && sel_valid;

    // One-hot ready towards the selected port only.
    always_comb begin
        ready_c = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && (sel == GW'(i))) begin
                ready_c[i] = 1'b1;
            end
        end
    end

    // Register accepted beats and track packet lock / round-robin pointer.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr           <= GW'(N - 1);
            lock_idx      <= '0;
            locked_q      <= 1'b0;
            grant_q       <= '0;
            out_valid_q   <= 1'b0;
            out_cmd_q     <= '0;
            out_dstaddr_q <= '0;
            out_srcaddr_q <= '0;
            out_data_q    <= '0;
        end else begin
            if (load) begin
                out_valid_q <= accept;
            end
            if (accept) begin
                out_cmd_q     <= sel_cmd;
                out_dstaddr_q <= sel_dstaddr;
                out_srcaddr_q <= sel_srcaddr;
                out_data_q    <= sel_data;
                grant_q       <= sel;
                if (sel_cmd[EOM_BIT]) begin
                    // Packet complete: release and let the next port in line win.
                    locked_q <= 1'b0;
                    ptr      <= sel;
                end else begin
                    locked_q <= 1'b1;
                    lock_idx <= sel;
                end
            end
        end
    end

    assign bus.in_ready    = ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_cmd     = out_cmd_q;
    assign bus.out_dstaddr = out_dstaddr_q;
    assign bus.out_srcaddr = out_srcaddr_q;
    assign bus.out_data    = out_data_q;
    assign bus.locked      = locked_q;
    assign bus.grant_id    = grant_q;
endmodule

// File: tb/tb_umi_stream_arbiter.sv
// Purpose: directed checks of the two-port UMI arbiter (round robin, lock, stall, reset).
// Latency: expects each accepted beat on the output one cycle later.
// Backpressure: exercises out_ready low with a full output stage.
module tb_umi_stream_arbiter;
    localparam int N       = 2;
    localparam int DW      = 256;
    localparam int AW      = 64;
    localparam int CW      = 32;
    localparam int EOM_BIT = 22;

    logic clk;
    logic nreset;
    int   n_cmp;
    int   n_bad;

    umi_stream_arbiter_if #(.N(N), .DW(DW), .AW(AW), .CW(CW)) bus ();

    umi_stream_arbiter #(
        .N(N), .DW(DW), .AW(AW), .CW(CW), .EOM_BIT(EOM_BIT)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic v, input logic eom, input logic [DW-1:0] dat);
        logic [CW-1:0] c;
        c = 32'h0000_0001;
        c[EOM_BIT] = eom;
        bus.in_valid[p]             = v;
        bus.in_cmd[p*CW +: CW]      = c;
        bus.in_data[p*DW +: DW]     = dat;
        bus.in_dstaddr[p*AW +: AW]  = dat[AW-1:0] + 64'h1000;
        bus.in_srcaddr[p*AW +: AW]  = ~dat[AW-1:0];
    endtask

    task automatic chk_ready(input string nm, input logic [N-1:0] exp);
        #1;
        n_cmp++;
        if (bus.in_ready !== exp) begin
            n_bad++;
            $display("FAIL %s: in_ready got %b want %b", nm, bus.in_ready, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input logic [0:0] g, input logic [DW-1:0] dat);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.grant_id !== g || bus.out_data !== dat) begin
            n_bad++;
            $display("FAIL %s: vld=%b grant=%0d data=%0h want vld=1 grant=%0d data=%0h",
                     nm, bus.out_valid, bus.grant_id, bus.out_data[31:0], g, dat[31:0]);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        bus.in_valid   = 2'b11;
        bus.in_cmd     = {$urandom, $urandom};
        bus.in_data    = {8{$urandom}};
        bus.in_dstaddr = {4{$urandom}};
        bus.in_srcaddr = {4{$urandom}};
        bus.out_ready  = 1'($urandom);
        repeat (2) tick();
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_bit("rst_locked", bus.locked, 1'b0);
        chk_bit("rst_grant", bus.grant_id, 1'b0);
        chk_ready("rst_in_ready", 2'b00);
        n_cmp++;
        if (bus.out_data !== '0 || bus.out_cmd !== '0) begin
            n_bad++;
            $display("FAIL rst_payload: data=%0h cmd=%0h want 0", bus.out_data[31:0], bus.out_cmd);
        end
        @(negedge clk);
        bus.in_valid   = '0;
        bus.in_cmd     = '0;
        bus.in_data    = '0;
        bus.in_dstaddr = '0;
        bus.in_srcaddr = '0;
        bus.out_ready  = 1'b1;
        nreset         = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [0:0]    exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [DW-1:0] exp_d [4] = '{256'hA0, 256'hA1, 256'hA0, 256'hA1};
        drive(0, 1'b1, 1'b1, 256'hA0);
        drive(1, 1'b1, 1'b1, 256'hA1);
        chk_ready("rr_first_ready", 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat($sformatf("rr_beat%0d", i), exp_g[i], exp_d[i]);
        end
        n_cmp++;
        if (bus.out_dstaddr !== 64'h10A1 || bus.out_srcaddr !== ~64'hA1) begin
            n_bad++;
            $display("FAIL rr_addr: dst=%0h src=%0h want 10a1 / %0h", bus.out_dstaddr, bus.out_srcaddr, ~64'hA1);
        end
        bus.in_valid = '0;
        tick();
        chk_bit("rr_drain", bus.out_valid, 1'b0);
    endtask

    task automatic test_lock();
        drive(0, 1'b1, 1'b1, 256'hB0);
        chk_ready("lk_pre_ready", 2'b01);
        tick();
        chk_beat("lk_pre_beat", 1'b0, 256'hB0);
        drive(1, 1'b1, 1'b0, 256'hB1);
        drive(0, 1'b1, 1'b1, 256'hC0);
        chk_ready("lk_b1_ready", 2'b10);
        tick();
        chk_beat("lk_b1", 1'b1, 256'hB1);
        chk_bit("lk_locked1", bus.locked, 1'b1);
        drive(1, 1'b1, 1'b0, 256'hB2);
        chk_ready("lk_b2_ready", 2'b10);
        tick();
        chk_beat("lk_b2", 1'b1, 256'hB2);
        chk_bit("lk_locked2", bus.locked, 1'b1);
        drive(1, 1'b1, 1'b1, 256'hB3);
        tick();
        chk_beat("lk_b3", 1'b1, 256'hB3);
        chk_bit("lk_unlocked", bus.locked, 1'b0);
        drive(1, 1'b0, 1'b1, 256'h0);
        chk_ready("lk_p0_ready", 2'b01);
        tick();
        chk_beat("lk_p0", 1'b0, 256'hC0);
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        drive(0, 1'b1, 1'b1, 256'hD0);
        drive(1, 1'b1, 1'b1, 256'hD1);
        tick();
        chk_beat("bp_first", 1'b1, 256'hD1);
        bus.out_ready = 1'b0;
        chk_ready("bp_ready_low", 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat($sformatf("bp_hold%0d", i), 1'b1, 256'hD1);
            chk_ready($sformatf("bp_ready%0d", i), 2'b00);
        end
        bus.out_ready = 1'b1;
        chk_ready("bp_release_ready", 2'b01);
        tick();
        chk_beat("bp_next", 1'b0, 256'hD0);
        bus.in_valid = '0;
        tick();
        chk_bit("bp_drain", bus.out_valid, 1'b0);
    endtask

    task automatic test_valid_gap();
        drive(1, 1'b1, 1'b0, 256'hE1);
        drive(0, 1'b1, 1'b1, 256'hF0);
        tick();
        chk_beat("gap_e1", 1'b1, 256'hE1);
        bus.in_valid[1] = 1'b0;
        chk_ready("gap_ready_none", 2'b00);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_bit($sformatf("gap_vld%0d", i), bus.out_valid, 1'b0);
            chk_bit($sformatf("gap_lock%0d", i), bus.locked, 1'b1);
        end
        drive(1, 1'b1, 1'b1, 256'hE2);
        chk_ready("gap_resume_ready", 2'b10);
        tick();
        chk_beat("gap_e2", 1'b1, 256'hE2);
        chk_bit("gap_unlocked", bus.locked, 1'b0);
        bus.in_valid[1] = 1'b0;
        tick();
        chk_beat("gap_f0", 1'b0, 256'hF0);
        bus.in_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        drive(1, 1'b1, 1'b0, 256'h11);
        tick();
        chk_beat("rmp_beat1", 1'b1, 256'h11);
        drive(1, 1'b1, 1'b0, 256'h12);
        tick();
        chk_beat("rmp_beat2", 1'b1, 256'h12);
        nreset = 1'b0;
        #1;
        chk_bit("rmp_locked", bus.locked, 1'b0);
        chk_bit("rmp_out_valid", bus.out_valid, 1'b0);
        chk_bit("rmp_grant", bus.grant_id, 1'b0);
        drive(1, 1'b1, 1'b1, 256'h13);
        drive(0, 1'b1, 1'b1, 256'h20);
        tick();
        nreset = 1'b1;
        chk_ready("rmp_port0_first", 2'b01);
        tick();
        chk_beat("rmp_port0_beat", 1'b0, 256'h20);
        bus.in_valid = '0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nreset = 1'b0;
        bus.in_valid   = '0;
        bus.in_cmd     = '0;
        bus.in_data    = '0;
        bus.in_dstaddr = '0;
        bus.in_srcaddr = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_valid_gap();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
